// File: rtl/cr_lz77_comp_sdec_pkg.sv
// Shared constants, token struct and skid-buffer state encoding for the
// LZ77 compressor match-select decoder.
package cr_lz77_comp_sdec_pkg;

  localparam int T_WIDTH  = 32;
  localparam int OI_WIDTH = 5;
  localparam int LEN_W    = $clog2(T_WIDTH + 1);
  localparam int MIN_LEN  = 3;

  typedef struct packed {
    logic                is_match;
    logic [LEN_W-1:0]    len;
    logic [OI_WIDTH-1:0] offset;
    logic                therm_err;
  } sdec_tok_t;

  typedef enum logic [1:0] {
    SDEC_EMPTY = 2'd0,
    SDEC_ONE   = 2'd1,
    SDEC_TWO   = 2'd2
  } sdec_state_e;

endpackage

// File: rtl/cr_lz77_comp_sdec_if.sv
// Input (tree root result) and output (token) handshake bundle of the decoder.
interface cr_lz77_comp_sdec_if;
  import cr_lz77_comp_sdec_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [T_WIDTH-1:0]  in_therm;
  logic [OI_WIDTH-1:0] in_offset;
  logic                out_valid;
  logic                out_ready;
  logic                out_is_match;
  logic [LEN_W-1:0]    out_len;
  logic [OI_WIDTH-1:0] out_offset;
  logic                out_therm_err;

  modport slave (
    input  in_valid, in_therm, in_offset, out_ready,
    output in_ready, out_valid, out_is_match, out_len, out_offset, out_therm_err
  );

  modport master (
    output in_valid, in_therm, in_offset, out_ready,
    input  in_ready, out_valid, out_is_match, out_len, out_offset, out_therm_err
  );

endinterface

// File: rtl/cr_lz77_comp_therm2bin.sv
// Combinational thermometer-to-length converter: counts contiguous ones from
// bit 0 and flags any set bit found above the first zero.
module cr_lz77_comp_therm2bin
  import cr_lz77_comp_sdec_pkg::*;
(
  input  logic [T_WIDTH-1:0] therm,
  output logic [LEN_W-1:0]   len,
  output logic               therm_err
);

  logic gap_s;

  // Scan LSB upward; once a zero is seen, further ones are malformed.
  always_comb begin
    len       = '0;
    therm_err = 1'b0;
    gap_s     = 1'b0;
    for (int i = 0; i < T_WIDTH; i++) begin
      if (therm[i]) begin
        if (gap_s) begin
          therm_err = 1'b1;
        end else begin
          len = len + LEN_W'(1);
        end
      end else begin
        gap_s = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_lz77_comp_sdec.sv
// Root match-select decoder: decodes the merged length code into a token,
// buffers it through a two-entry skid stage and keeps token statistics.
module cr_lz77_comp_sdec
  import cr_lz77_comp_sdec_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  cr_lz77_comp_sdec_if.slave     bus,
  input  logic                   clr_stats,
  output logic [31:0]            match_cnt,
  output logic [31:0]            lit_cnt,
  output logic [15:0]            err_cnt
);

  logic [LEN_W-1:0] dec_len_s;
  logic             dec_err_s;
  sdec_tok_t        dec_tok_s;

  sdec_state_e state_q, state_d;
  sdec_tok_t   out_q, out_d, skid_q, skid_d;
  logic        out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic [31:0] match_cnt_q, match_cnt_d, lit_cnt_q, lit_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        in_fire_s, out_fire_s;

  cr_lz77_comp_therm2bin u_therm2bin (
    .therm     (bus.in_therm),
    .len       (dec_len_s),
    .therm_err (dec_err_s)
  );

  // Literals carry no length/offset; the code error is still reported.
  always_comb begin
    dec_tok_s.is_match  = (dec_len_s >= LEN_W'(MIN_LEN));
    dec_tok_s.therm_err = dec_err_s;
    if (dec_tok_s.is_match) begin
      dec_tok_s.len    = dec_len_s;
      dec_tok_s.offset = bus.in_offset;
    end else begin
      dec_tok_s.len    = '0;
      dec_tok_s.offset = '0;
    end
  end

  assign in_fire_s  = bus.in_valid & in_ready_q;
  assign out_fire_s = out_valid_q & bus.out_ready;

  // Skid-buffer next state; in_ready depends only on state so it can be a flop.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      SDEC_EMPTY: begin
        if (in_fire_s) begin
          out_d       = dec_tok_s;
          state_d     = SDEC_ONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = SDEC_EMPTY;
        end
      end
      SDEC_ONE: begin
        if (in_fire_s && !out_fire_s) begin
          skid_d     = dec_tok_s;
          state_d    = SDEC_TWO;
          in_ready_d = 1'b0;
        end else if (in_fire_s && out_fire_s) begin
          out_d = dec_tok_s;
        end else if (out_fire_s) begin
          state_d     = SDEC_EMPTY;
          out_valid_d = 1'b0;
        end else begin
          state_d = SDEC_ONE;
        end
      end
      SDEC_TWO: begin
        if (out_fire_s) begin
          out_d      = skid_q;
          state_d    = SDEC_ONE;
          in_ready_d = 1'b1;
        end else begin
          state_d = SDEC_TWO;
        end
      end
      default: begin
        state_d     = SDEC_EMPTY;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // Statistics follow the token leaving the stage; clear wins over increments.
  always_comb begin
    match_cnt_d = match_cnt_q;
    lit_cnt_d   = lit_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (clr_stats) begin
      match_cnt_d = 32'd0;
      lit_cnt_d   = 32'd0;
      err_cnt_d   = 16'd0;
    end else if (out_fire_s) begin
      if (out_q.is_match) begin
        match_cnt_d = match_cnt_q + 32'd1;
      end else begin
        lit_cnt_d = lit_cnt_q + 32'd1;
      end
      if (out_q.therm_err && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, payload and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SDEC_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      match_cnt_q <= 32'd0;
      lit_cnt_q   <= 32'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      match_cnt_q <= match_cnt_d;
      lit_cnt_q   <= lit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_is_match  = out_q.is_match;
  assign bus.out_len       = out_q.len;
  assign bus.out_offset    = out_q.offset;
  assign bus.out_therm_err = out_q.therm_err;
  assign match_cnt         = match_cnt_q;
  assign lit_cnt           = lit_cnt_q;
  assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_cr_lz77_comp_sdec.sv
// Scoreboard bench for cr_lz77_comp_sdec: directed tokens with hand-computed
// expectations, checked by an independent output monitor.
module tb_cr_lz77_comp_sdec;
  import cr_lz77_comp_sdec_pkg::*;

  logic        clk;
  logic        rst;
  logic        clr_stats;
  logic [31:0] match_cnt;
  logic [31:0] lit_cnt;
  logic [15:0] err_cnt;

  int n_checks;
  int n_fail;
  sdec_tok_t sb[$];

  cr_lz77_comp_sdec_if bus ();

  cr_lz77_comp_sdec dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_stats (clr_stats),
    .match_cnt (match_cnt),
    .lit_cnt   (lit_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sdec_tok_t mk(input logic m, input logic [5:0] l,
                                   input logic [4:0] o, input logic e);
    sdec_tok_t t;
    t.is_match  = m;
    t.len       = l;
    t.offset    = o;
    t.therm_err = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one token; push its expectation at the edge where it is accepted.
  task automatic send(input logic [31:0] th, input logic [4:0] off, input sdec_tok_t exp);
    bit ok;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_therm  = th;
    bus.in_offset = off;
    for (int k = 0; k < 100; k++) begin
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    if (ok) begin
      sb.push_back(exp);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: therm 0x%0h never accepted", th);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0 && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d tokens outstanding, out_valid %0b", sb.size(), bus.out_valid);
    end
  endtask

  // Output monitor: every output fire must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL token_unexpected: m=%0b len=%0d off=%0d err=%0b with nothing expected",
                 bus.out_is_match, bus.out_len, bus.out_offset, bus.out_therm_err);
      end else begin
        sdec_tok_t e;
        e = sb.pop_front();
        if (bus.out_is_match !== e.is_match || bus.out_len !== e.len ||
            bus.out_offset !== e.offset || bus.out_therm_err !== e.therm_err) begin
          n_fail++;
          $display("FAIL token: got m=%0b len=%0d off=%0d err=%0b, expected m=%0b len=%0d off=%0d err=%0b",
                   bus.out_is_match, bus.out_len, bus.out_offset, bus.out_therm_err,
                   e.is_match, e.len, e.offset, e.therm_err);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    clr_stats     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_therm  = 32'h0;
    bus.in_offset = 5'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_payload", {bus.out_is_match, bus.out_len, bus.out_offset, bus.out_therm_err}, 32'd0);
    chk("rst_counters", match_cnt | lit_cnt | {16'd0, err_cnt}, 32'd0);

    send(32'h0000_001F, 5'd7, mk(1'b1, 6'd5, 5'd7, 1'b0));
    drain();
    chk("match_cnt_1", match_cnt, 32'd1);
    send(32'h0000_0003, 5'd9, mk(1'b0, 6'd0, 5'd0, 1'b0));
    drain();
    chk("lit_cnt_1", lit_cnt, 32'd1);
    send(32'h0000_00F3, 5'd4, mk(1'b0, 6'd0, 5'd0, 1'b1));
    drain();
    chk("err_cnt_1", {16'd0, err_cnt}, 32'd1);
    chk("lit_cnt_2", lit_cnt, 32'd2);

    // Length boundaries streamed back to back.
    send(32'h0000_0007, 5'd4,  mk(1'b1, 6'd3,  5'd4,  1'b0));
    send(32'h0000_000B, 5'd6,  mk(1'b0, 6'd0,  5'd0,  1'b1));
    send(32'hFFFF_FFFF, 5'd31, mk(1'b1, 6'd32, 5'd31, 1'b0));
    send(32'h0000_0000, 5'd3,  mk(1'b0, 6'd0,  5'd0,  1'b0));
    send(32'h8000_0000, 5'd2,  mk(1'b0, 6'd0,  5'd0,  1'b1));
    drain();
    chk("match_cnt_3", match_cnt, 32'd3);
    chk("lit_cnt_5", lit_cnt, 32'd5);
    chk("err_cnt_3", {16'd0, err_cnt}, 32'd3);

    // Backpressure: two accepts fill the stage, then a gap-free drain.
    bus.out_ready = 1'b0;
    send(32'h0000_000F, 5'd1, mk(1'b1, 6'd4, 5'd1, 1'b0));
    chk("ready_after_1", {31'd0, bus.in_ready}, 32'd1);
    send(32'h0000_0001, 5'd2, mk(1'b0, 6'd0, 5'd0, 1'b0));
    chk("ready_after_2", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    fork
      begin
        send(32'h0000_003F, 5'd3,  mk(1'b1, 6'd6,  5'd3,  1'b0));
        send(32'h7FFF_FFFF, 5'd30, mk(1'b1, 6'd31, 5'd30, 1'b0));
      end
      begin
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("stream_no_gap", {31'd0, bus.out_valid}, 32'd1);
        end
      end
    join
    drain();
    chk("match_cnt_6", match_cnt, 32'd6);
    chk("lit_cnt_6", lit_cnt, 32'd6);

    clr_stats = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    chk("clr_counters", match_cnt | lit_cnt | {16'd0, err_cnt}, 32'd0);

    // Saturation of the error counter.
    for (int n = 0; n < 65535; n++) begin
      send(32'h0000_0002, 5'd0, mk(1'b0, 6'd0, 5'd0, 1'b1));
    end
    drain();
    chk("err_cnt_full", {16'd0, err_cnt}, 32'h0000_FFFF);
    chk("lit_cnt_65535", lit_cnt, 32'd65535);
    send(32'h0000_0002, 5'd0, mk(1'b0, 6'd0, 5'd0, 1'b1));
    drain();
    chk("err_cnt_sat", {16'd0, err_cnt}, 32'h0000_FFFF);
    chk("lit_cnt_65536", lit_cnt, 32'd65536);

    // Clear coincident with a match leaving the stage.
    bus.out_ready = 1'b0;
    send(32'h0000_001F, 5'd5, mk(1'b1, 6'd5, 5'd5, 1'b0));
    bus.out_ready = 1'b1;
    clr_stats     = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    chk("clr_vs_fire", match_cnt | lit_cnt | {16'd0, err_cnt}, 32'd0);
    drain();

    // Asynchronous reset while both entries are full.
    bus.out_ready = 1'b0;
    send(32'h0000_00FF, 5'd8,  mk(1'b1, 6'd8, 5'd8,  1'b0));
    send(32'h0000_0007, 5'd10, mk(1'b1, 6'd3, 5'd10, 1'b0));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_stale_token", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(32'h0000_007F, 5'd12, mk(1'b1, 6'd7, 5'd12, 1'b0));
    drain();
    chk("post_rst_match_cnt", match_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_lz77_comp_sdec.md
# cr_lz77_comp_sdec

Match-select decoder at the root of the LZ77 compressor's longest-match reduction tree. It accepts the merged thermometer length code and binary candidate offset from the final selection node. It converts these to a binary match length, classifies the result as match or literal, and emits a token through a registered valid/ready skid stage toward the token packer. It also keeps match, literal and malformed-code statistics.

## Interface
- T_WIDTH, 32, thermometer width; bit i set means match length ≥ i+1
- OI_WIDTH, 5, offset index width from the tree root
- LEN_W, $clog2(T_WIDTH+1) = 6, binary length width
- MIN_LEN, 3, minimum length reported as a match
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  root node result valid
- in_ready  out  1  decoder can accept; registered
- in_therm  in  T_WIDTH  merged thermometer code
- in_offset  in  OI_WIDTH  winning candidate index
- out_valid  out  1  token valid
- out_ready  in  1  downstream accepts
- out_is_match  out  1  1 = match token, 0 = literal
- out_len  out  LEN_W  decoded length; 0 for a literal
- out_offset  out  OI_WIDTH  candidate index; 0 for a literal
- out_therm_err  out  1  input code was not contiguous-from-LSB
- clr_stats  in  1  synchronous single-cycle clear of all counters
- match_cnt  out  32  matches emitted; wraps
- lit_cnt  out  32  literals emitted; wraps
- err_cnt  out  16  malformed codes; saturates at 0xFFFF

## Operation
- Input fire: in_valid & in_ready. Output fire: out_valid & out_ready.
- Decode is combinational on the input side and registered into the output/skid stage.
  - len = number of contiguous 1s starting at bit 0.
  - therm_err = 1 if any 1 exists above the first 0.
  - is_match = (len ≥ MIN_LEN).
  - Literal forces out_len = 0 and out_offset = 0. therm_err is still reported for literals.
- Length example: 0x0000_0007 gives len 3, no error. 0x0000_000B gives len 2 and therm_err = 1. 0xFFFF_FFFF gives len 32.
- Buffer FSM (two entries: OUT register and SKID register):
  - EMPTY: out_valid = 0, in_ready = 1. Input fire loads OUT and moves to ONE.
  - ONE: out_valid = 1, in_ready = 1.
    - Input fire without output fire loads SKID and moves to TWO; in_ready drops next cycle.
    - Input fire with output fire loads OUT and stays in ONE.
    - Output fire alone moves to EMPTY.
  - TWO: out_valid = 1, in_ready = 0. Output fire moves SKID into OUT and returns to ONE.
- Tokens leave in acceptance order; none is ever dropped or duplicated.
- Counters update on output fire, not on input fire.
  - match_cnt increments on match tokens; lit_cnt increments on literals.
  - err_cnt increments on tokens with therm_err = 1, in addition to the match or literal count.
- clr_stats has priority: a coincident increment is discarded and all counters read 0 next cycle.

## Timing
- Reset values: out_valid 0, in_ready 1, out_is_match 0, out_len 0, out_offset 0, out_therm_err 0, all counters 0. FSM starts in EMPTY.
- Latency: input fire in cycle N gives out_valid in cycle N+1.
- Throughput: one token per cycle while out_ready is held high.
- in_ready is a flop output with no combinational path from out_ready, so out_ready may be driven combinationally from downstream.
- out_* payload is stable while out_valid & !out_ready.
- Reset asserted mid-operation returns the block to EMPTY and discards both entries. Counters clear.
- Counters reflect a fired token one cycle after the fire.

## Structure
- Constants and typedefs go in cr_lz77_comp.vh/package: sdec_tok_t struct {is_match, len, offset, therm_err} and the FSM state enum {SDEC_EMPTY, SDEC_ONE, SDEC_TWO}.
- One sub-module, cr_lz77_comp_therm2bin: purely combinational thermometer-to-length and error detection, reusable by the debug path.
- The skid FSM and the counters live in the top module.

## Test plan
- Reset, then in_therm 0x0000_001F with offset 7 and out_ready = 1: next cycle is_match = 1, len 5, offset 7, err 0; match_cnt = 1.
- in_therm 0x0000_0003 with offset 9: literal with len 0 and offset 0; lit_cnt = 1.
- in_therm 0x0000_00F3: len 2, literal, therm_err = 1; err_cnt = 1 and lit_cnt increments.
- Stream four tokens while out_ready is low: in_ready drops after the second accept. Raising out_ready yields all four in order with no gap once flowing.
- Preload err_cnt to 0xFFFF via 65535 error tokens, then send one more error token: err_cnt stays 0xFFFF. clr_stats coincident with a match fire: all counters read 0.
- Assert rst while in state TWO: out_valid = 0 and in_ready = 1 in the same cycle (asynchronous), and no stale token appears after release.
